payload_byte_feeder: RTL

- Front-end stage directly upstream of the payload regex engines.
- Accepts packet payload as an AXI4-Stream-style word stream and serialises it to one byte per cycle.
- Produces the engine control strobes: sod (clears engine state before a packet), en (byte valid / flop enable) and eod (end of packet, sample engine outputs).
- Produces the 256-line one-hot character decode bus; engines tap individual lines as their in_N inputs.

---
 rtl/payload_byte_feeder_if.sv | 22 ++
 rtl/payload_byte_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/payload_byte_feeder_if.sv
// payload_byte_feeder_if
//   AXI4-Stream-style word stream carrying packet payload into the byte
//   feeder.
//   s_tdata  : payload word, lane 0 = bits [7:0] goes out first
//   s_tkeep  : lane-valid mask, contiguous from lane 0
//   s_tlast  : final word of a packet
//   s_tvalid : word valid
//   s_tready : word accepted on s_tvalid & s_tready at a rising edge
// master = word source, slave = payload_byte_feeder.
interface payload_byte_feeder_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
);
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;

  modport master (output s_tdata, s_tkeep, s_tlast, s_tvalid, input s_tready);
  modport slave  (input s_tdata, s_tkeep, s_tlast, s_tvalid, output s_tready);
endinterface

// File: rtl/payload_byte_feeder.sv
// payload_byte_feeder
//   Serialises a payload word stream into one byte per cycle for the regex
//   engines, with the engine control strobes and a one-hot character decode.
//   clk, rst    : single clock, synchronous active-high reset
//   s           : word stream (slave side of payload_byte_feeder_if)
//   sod         : one-cycle pulse before the first byte (engine clear)
//   en          : byte_data / char_dec valid this cycle
//   byte_data   : current payload byte, held while en is low
//   char_dec    : bit b = en & (byte_data == b)
//   byte_offset : byte index within the packet, saturating
//   eod         : one-cycle pulse after the last byte (sample engines)
// Every output, including s_tready, comes straight from a flop. The next
// state is computed first, and all outputs are derived from it, so the
// registered outputs always describe the state the FSM is in.
module payload_byte_feeder #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int OFS_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  payload_byte_feeder_if.slave  s,
  output logic                  sod,
  output logic                  en,
  output logic [7:0]            byte_data,
  output logic [255:0]          char_dec,
  output logic [OFS_W-1:0]      byte_offset,
  output logic                  eod
);
  localparam int LANE_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam int CNT_W  = $clog2(KEEP_W + 1);

  typedef enum logic [2:0] {IDLE, SOD, BYTES, WAIT, EOD} state_e;

  state_e                   state_q, state_d;
  logic [KEEP_W-1:0][7:0]   word_q, word_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     last_q, last_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic                     first_q, first_d;
  logic                     rdy_q, rdy_d;
  logic                     sod_q, sod_d;
  logic                     en_q, en_d;
  logic                     eod_q, eod_d;
  logic [7:0]               byte_q, byte_d;
  logic [255:0]             dec_q, dec_d;
  logic [OFS_W-1:0]         ofs_q, ofs_d;

  logic                     accept;
  logic                     last_lane;
  logic [CNT_W-1:0]         in_cnt;

  // Lanes counted only while keep stays set from lane 0 upward.
  function automatic logic [CNT_W-1:0] lead_ones(input logic [KEEP_W-1:0] k);
    logic [CNT_W-1:0] c;
    logic             run;
    c   = '0;
    run = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (run && k[i]) c = c + CNT_W'(1);
      else             run = 1'b0;
    end
    return c;
  endfunction

  assign accept    = s.s_tvalid & rdy_q;
  assign in_cnt    = lead_ones(s.s_tkeep);
  assign last_lane = (CNT_W'(lane_q) + CNT_W'(1)) == cnt_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = s.s_tdata;
          cnt_d   = in_cnt;
          last_d  = s.s_tlast;
          state_d = SOD;
        end
      end
      SOD: begin
        if (cnt_q == '0) state_d = last_q ? EOD : WAIT;
        else begin
          state_d = BYTES;
          lane_d  = '0;
        end
      end
      BYTES: begin
        if (!last_lane) lane_d = lane_q + LANE_W'(1);
        else if (last_q) state_d = EOD;
        else if (accept) begin
          // Back-to-back word: its lane 0 follows with no bubble.
          word_d = s.s_tdata;
          cnt_d  = in_cnt;
          last_d = s.s_tlast;
          if (in_cnt == '0) state_d = s.s_tlast ? EOD : WAIT;
          else begin
            state_d = BYTES;
            lane_d  = '0;
          end
        end else state_d = WAIT;
      end
      WAIT: begin
        if (accept) begin
          word_d = s.s_tdata;
          cnt_d  = in_cnt;
          last_d = s.s_tlast;
          if (in_cnt == '0) state_d = s.s_tlast ? EOD : WAIT;
          else begin
            state_d = BYTES;
            lane_d  = '0;
          end
        end
      end
      EOD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the cycle the FSM is about to enter.
  always_comb begin
    sod_d = (state_d == SOD);
    en_d  = (state_d == BYTES);
    eod_d = (state_d == EOD);
    // Ready only in states that can take a word next edge: idle, starved,
    // or emitting the final lane of a non-last word.
    rdy_d = (state_d == IDLE) || (state_d == WAIT) ||
            ((state_d == BYTES) && !last_d &&
             ((CNT_W'(lane_d) + CNT_W'(1)) == cnt_d));
    byte_d  = en_d ? word_d[lane_d] : byte_q;
    dec_d   = en_d ? (256'(1) << byte_d) : '0;
    first_d = first_q;
    ofs_d   = ofs_q;
    if (sod_d) begin
      ofs_d   = '0;
      first_d = 1'b1;
    end else if (en_d) begin
      first_d = 1'b0;
      // First byte keeps the cleared 0; later bytes count up and stick at max.
      if (!first_q && (ofs_q != '1)) ofs_d = ofs_q + OFS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      first_q <= 1'b0;
      rdy_q   <= 1'b0;
      sod_q   <= 1'b0;
      en_q    <= 1'b0;
      eod_q   <= 1'b0;
      byte_q  <= '0;
      dec_q   <= '0;
      ofs_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
      first_q <= first_d;
      rdy_q   <= rdy_d;
      sod_q   <= sod_d;
      en_q    <= en_d;
      eod_q   <= eod_d;
      byte_q  <= byte_d;
      dec_q   <= dec_d;
      ofs_q   <= ofs_d;
    end
  end

  assign s.s_tready  = rdy_q;
  assign sod         = sod_q;
  assign en          = en_q;
  assign eod         = eod_q;
  assign byte_data   = byte_q;
  assign char_dec    = dec_q;
  assign byte_offset = ofs_q;
endmodule
